// File: rtl/mc_pkg.sv
// Shared sizes, sample payload type and collector state encoding for the
// Monte-Carlo FFT->MULT->IFFT datapath.
package mc_pkg;

  localparam int unsigned MC_N  = 256;
  localparam int unsigned MC_DW = 16;
  localparam int unsigned MC_AW = 8;

  typedef struct packed {
    logic signed [MC_DW-1:0] re;
    logic signed [MC_DW-1:0] img;
  } cplx16_t;

  // Collector FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/mc_frame_buf.sv
// N-entry complex-sample frame buffer: one write port, one asynchronous read
// port, contents deliberately left unreset.
module mc_frame_buf
  import mc_pkg::*;
#(
  parameter int unsigned N  = MC_N,
  parameter int unsigned AW = MC_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cplx16_t       wdata,
  input  logic [AW-1:0] raddr,
  output cplx16_t       rdata_c
);

  cplx16_t mem_q [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/mc_frame_collector.sv
// Captures one N-sample complex burst and replays it over a valid/ready port.
// Optional running frame checksum output is enabled by MC_FRAME_CHECKSUM_EN.
module mc_frame_collector
  import mc_pkg::*;
#(
  parameter int unsigned N  = MC_N,
  parameter int unsigned DW = MC_DW,
  parameter int unsigned AW = MC_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] y_real,
  input  logic signed [DW-1:0] y_img,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic signed [DW-1:0] rd_real,
  output logic signed [DW-1:0] rd_img,
  output logic [AW-1:0]        rd_idx,
  output logic                 rd_last,
  output logic                 overrun,
  input  logic                 overrun_clr
`ifdef MC_FRAME_CHECKSUM_EN
  ,
  output logic [31:0]          frame_sum
`endif
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          overrun_q, overrun_d;
  logic          we_c, hs_c, last_hs_c;
  cplx16_t       wr_data_c, rd_data_c;

  assign wr_data_c.re  = y_real;
  assign wr_data_c.img = y_img;

  mc_frame_buf #(
    .N  (N),
    .AW (AW)
  ) u_buf (
    .clk     (clk),
    .we      (we_c),
    .waddr   (wr_ptr_q),
    .wdata   (wr_data_c),
    .raddr   (rd_ptr_q),
    .rdata_c (rd_data_c)
  );

  // Next state; the final read handshake may also accept sample 0 of the next frame
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q & ~overrun_clr;
    we_c         = 1'b0;
    hs_c         = rd_valid_q & rd_ready;
    last_hs_c    = hs_c & (rd_ptr_q == LAST_IDX);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == LAST_IDX) begin
            state_d      = ST_DRAIN;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (hs_c) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (last_hs_c) begin
          state_d = ST_IDLE;
        end
        if (in_valid) begin
          if (last_hs_c) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            state_d  = ST_CAPTURE;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d     = (state_d != ST_IDLE);
    rd_valid_d = (state_d == ST_DRAIN);
    rd_last_d  = (state_d == ST_DRAIN) && (rd_ptr_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign rd_valid   = rd_valid_q;
  assign rd_idx     = rd_ptr_q;
  assign rd_last    = rd_last_q;
  assign overrun    = overrun_q;
  // Buffer is unreset, so read data is forced to zero outside DRAIN
  assign rd_real    = rd_valid_q ? rd_data_c.re  : '0;
  assign rd_img     = rd_valid_q ? rd_data_c.img : '0;

`ifdef MC_FRAME_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] frame_sum_q, frame_sum_d;
  logic [31:0] sample_sum_c;

  // Running sum restarts on sample 0; published alongside frame_done
  always_comb begin
    sample_sum_c = 32'(y_real) + 32'(y_img);
    acc_d        = acc_q;
    if (we_c) begin
      acc_d = (wr_ptr_q == '0) ? sample_sum_c : acc_q + sample_sum_c;
    end
    frame_sum_d = frame_done_d ? acc_d : frame_sum_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`endif

endmodule

// File: tb/tb_mc_frame_collector.sv
// Self-checking bench for mc_frame_collector against a frame-level reference
// model (expected frame arrays, expected sticky overrun, expected checksum).
`timescale 1ns/1ps
module tb_mc_frame_collector;

  localparam int N = 256;

  logic clk = 1'b0;
  logic rst_n, in_valid, rd_ready, overrun_clr;
  logic signed [15:0] y_real, y_img;
  logic frame_done, busy, rd_valid, rd_last, overrun;
  logic signed [15:0] rd_real, rd_img;
  logic [7:0] rd_idx;
`ifdef MC_FRAME_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  int n_checks = 0;
  int n_pass = 0;
  logic signed [15:0] exp_re [N];
  logic signed [15:0] exp_im [N];
  logic signed [15:0] nxt_re [N];
  logic signed [15:0] nxt_im [N];
  logic exp_ovr;

  always #5 clk = ~clk;

  mc_frame_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .y_real      (y_real),
    .y_img       (y_img),
    .frame_done  (frame_done),
    .busy        (busy),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_real     (rd_real),
    .rd_img      (rd_img),
    .rd_idx      (rd_idx),
    .rd_last     (rd_last),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef MC_FRAME_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

`ifdef MC_FRAME_CHECKSUM_EN
  function automatic logic [31:0] model_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < N; i++)
      s = s + 32'(int'(exp_re[8'(i)])) + 32'(int'(exp_im[8'(i)]));
    return s;
  endfunction
`endif

  // Fill the next-frame model: 0 ramp, 1 random, 2 constant (1,2), 3 zeros
  task automatic gen_frame(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       begin nxt_re[8'(i)] = 16'(i);        nxt_im[8'(i)] = 16'(-i); end
        1:       begin nxt_re[8'(i)] = 16'($urandom); nxt_im[8'(i)] = 16'($urandom); end
        2:       begin nxt_re[8'(i)] = 16'sd1;        nxt_im[8'(i)] = 16'sd2; end
        default: begin nxt_re[8'(i)] = 16'sd0;        nxt_im[8'(i)] = 16'sd0; end
      endcase
    end
  endtask

  // Feed exp[start..N-1]; gap_mode 0 contiguous, 1 alternate, 2 random
  task automatic capture(input int gap_mode, input int start);
    int idx = start;
    int budget = 4000;
    bit v = 1'b0;
    while (idx < N && budget > 0) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (idx == start && !v) ? 1'b1 : ~v;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      y_real = exp_re[8'(idx)];
      y_img  = exp_im[8'(idx)];
      @(posedge clk); #1;
      budget--;
      in_valid = 1'b0;
      if (v) idx++;
      if (idx < N) begin
        n_checks++; if (frame_done !== 1'b0) $display("FAIL cap_frame_done_early idx=%0d got %b exp 0", idx, frame_done); else n_pass++;
        n_checks++; if (busy !== (idx > 0)) $display("FAIL cap_busy idx=%0d got %b exp %b", idx, busy, idx > 0); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL cap_rd_valid idx=%0d got %b exp 0", idx, rd_valid); else n_pass++;
        n_checks++; if (overrun !== exp_ovr) $display("FAIL cap_overrun idx=%0d got %b exp %b", idx, overrun, exp_ovr); else n_pass++;
      end
    end
    n_checks++; if (idx < N) $display("FAIL cap_timeout got %0d samples exp %0d", idx, N); else n_pass++;
    n_checks++; if (frame_done !== 1'b1) $display("FAIL cap_frame_done got %b exp 1", frame_done); else n_pass++;
    n_checks++; if (rd_valid !== 1'b1) $display("FAIL cap_first_rd_valid got %b exp 1", rd_valid); else n_pass++;
    n_checks++; if (rd_idx !== 8'd0) $display("FAIL cap_first_rd_idx got %0d exp 0", rd_idx); else n_pass++;
`ifdef MC_FRAME_CHECKSUM_EN
    n_checks++; if (frame_sum !== model_sum()) $display("FAIL cap_frame_sum got %0h exp %0h", frame_sum, model_sum()); else n_pass++;
`endif
  endtask

  // Read the frame back; rdy_mode 0 always, 1 pattern 1,0,0,1, 2 random.
  // chain=1 presents nxt[0] in the cycle of the final handshake.
  task automatic drain(input int rdy_mode, input bit chain);
    int k = 0;
    int c = 0;
    int budget = 4000;
    bit r;
    while (k < N && budget > 0) begin
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL drn_rd_valid k=%0d got %b exp 1", k, rd_valid); else n_pass++;
      n_checks++; if (rd_idx !== 8'(k)) $display("FAIL drn_rd_idx got %0d exp %0d", rd_idx, k); else n_pass++;
      n_checks++; if (rd_real !== exp_re[8'(k)]) $display("FAIL drn_rd_real k=%0d got %0d exp %0d", k, rd_real, exp_re[8'(k)]); else n_pass++;
      n_checks++; if (rd_img !== exp_im[8'(k)]) $display("FAIL drn_rd_img k=%0d got %0d exp %0d", k, rd_img, exp_im[8'(k)]); else n_pass++;
      n_checks++; if (rd_last !== (k == N - 1)) $display("FAIL drn_rd_last k=%0d got %b exp %b", k, rd_last, k == N - 1); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL drn_busy k=%0d got %b exp 1", k, busy); else n_pass++;
      n_checks++; if (overrun !== exp_ovr) $display("FAIL drn_overrun k=%0d got %b exp %b", k, overrun, exp_ovr); else n_pass++;
      if (c > 0) begin
        n_checks++; if (frame_done !== 1'b0) $display("FAIL drn_frame_done_extra k=%0d got %b exp 0", k, frame_done); else n_pass++;
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (c % 4 == 0) || (c % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rd_ready = r;
      if (chain && r && k == N - 1) begin
        in_valid = 1'b1;
        y_real = nxt_re[0];
        y_img  = nxt_im[0];
      end
      @(posedge clk); #1;
      budget--;
      c++;
      rd_ready = 1'b0;
      in_valid = 1'b0;
      if (r) k++;
    end
    n_checks++; if (k < N) $display("FAIL drn_timeout got %0d reads exp %0d", k, N); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL drn_end_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_checks++; if (busy !== chain) $display("FAIL drn_end_busy got %b exp %b", busy, chain); else n_pass++;
    n_checks++; if (overrun !== exp_ovr) $display("FAIL drn_end_overrun got %b exp %b", overrun, exp_ovr); else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({frame_done, busy, rd_valid, rd_last, overrun} !== 5'b0) $display("FAIL rst_flags got %b exp 00000", {frame_done, busy, rd_valid, rd_last, overrun}); else n_pass++;
    n_checks++; if ({rd_real, rd_img, rd_idx} !== 40'h0) $display("FAIL rst_data got %0h exp 0", {rd_real, rd_img, rd_idx}); else n_pass++;
`ifdef MC_FRAME_CHECKSUM_EN
    n_checks++; if (frame_sum !== 32'h0) $display("FAIL rst_frame_sum got %0h exp 0", frame_sum); else n_pass++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_contiguous();
    gen_frame(0); exp_re = nxt_re; exp_im = nxt_im;
    capture(0, 0);
    drain(0, 1'b0);
  endtask

  task automatic test_gapped_backpressure();
    gen_frame(0); exp_re = nxt_re; exp_im = nxt_im;
    capture(1, 0);
    drain(1, 1'b0);
  endtask

  task automatic test_overrun();
    gen_frame(1); exp_re = nxt_re; exp_im = nxt_im;
    capture(0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; y_real = 16'($urandom); y_img = 16'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_ovr = 1'b1;
      n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set i=%0d got %b exp 1", i, overrun); else n_pass++;
      n_checks++; if (rd_idx !== 8'd0 || rd_real !== exp_re[0] || rd_img !== exp_im[0]) $display("FAIL ovr_read_hold i=%0d got idx %0d re %0d exp idx 0 re %0d", i, rd_idx, rd_real, exp_re[0]); else n_pass++;
    end
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0; exp_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", overrun); else n_pass++;
    overrun_clr = 1'b1; in_valid = 1'b1; y_real = 16'($urandom); y_img = 16'($urandom);
    @(posedge clk); #1;
    overrun_clr = 1'b0; in_valid = 1'b0; exp_ovr = 1'b1;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b exp 1", overrun); else n_pass++;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0; exp_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear2 got %b exp 0", overrun); else n_pass++;
    drain(2, 1'b0);
  endtask

  task automatic test_back_to_back();
    gen_frame(1); exp_re = nxt_re; exp_im = nxt_im;
    capture(0, 0);
    gen_frame(1);
    drain(0, 1'b1);
    exp_re = nxt_re; exp_im = nxt_im;
    capture(1, 1);
    drain(1, 1'b0);
  endtask

  task automatic test_reset_mid();
    gen_frame(1); exp_re = nxt_re; exp_im = nxt_im;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; y_real = exp_re[8'(i)]; y_img = exp_im[8'(i)];
      @(posedge clk); #1;
      n_checks++; if (frame_done !== 1'b0 || busy !== 1'b1) $display("FAIL mid_partial i=%0d got fd %b busy %b exp fd 0 busy 1", i, frame_done, busy); else n_pass++;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if ({frame_done, busy, rd_valid, rd_last, overrun} !== 5'b0) $display("FAIL mid_rst_flags got %b exp 00000", {frame_done, busy, rd_valid, rd_last, overrun}); else n_pass++;
    n_checks++; if ({rd_real, rd_img, rd_idx} !== 40'h0) $display("FAIL mid_rst_data got %0h exp 0", {rd_real, rd_img, rd_idx}); else n_pass++;
`ifdef MC_FRAME_CHECKSUM_EN
    n_checks++; if (frame_sum !== 32'h0) $display("FAIL mid_rst_frame_sum got %0h exp 0", frame_sum); else n_pass++;
`endif
    gen_frame(1); exp_re = nxt_re; exp_im = nxt_im;
    capture(2, 0);
    drain(2, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      gen_frame(1); exp_re = nxt_re; exp_im = nxt_im;
      capture(2, 0);
      drain(2, 1'b0);
    end
  endtask

`ifdef MC_FRAME_CHECKSUM_EN
  task automatic test_checksum();
    gen_frame(2); exp_re = nxt_re; exp_im = nxt_im;
    capture(0, 0);
    n_checks++; if (frame_sum !== 32'd768) $display("FAIL sum_const got %0d exp 768", frame_sum); else n_pass++;
    drain(2, 1'b0);
    n_checks++; if (frame_sum !== 32'd768) $display("FAIL sum_hold got %0d exp 768", frame_sum); else n_pass++;
    gen_frame(3); exp_re = nxt_re; exp_im = nxt_im;
    capture(1, 0);
    n_checks++; if (frame_sum !== 32'd0) $display("FAIL sum_zero got %0d exp 0", frame_sum); else n_pass++;
    drain(0, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    y_real = '0; y_img = '0; exp_ovr = 1'b0;
    test_reset();
    test_contiguous();
    test_gapped_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MC_FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
